// File: rtl/fetch_unit.sv
// fetch_unit: IF stage of the RV32IM 5-stage core. It owns the PC and fetches
// from instruction memory with one request outstanding at a time. Returned
// instructions go into an output slot and a one-entry skid, which are then
// presented to the IF/ID register.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   stallF                     IF/ID holds this cycle (slot not consumed)
//   redirect_valid/pc          taken branch/jump from EX (single-cycle pulse)
//   imem_req/addr/ready        fetch request (valid/ready)
//   imem_rvalid/rdata          fetch response (valid only)
//   pc_plus4F/instrF/validF    instruction presented to IF/ID
//   fetch_count                instructions consumed by IF/ID (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus4F,
    output logic [31:0] instrF,
    output logic        validF,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {StIssue, StWait, StBlocked} state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic [31:0] pc_q, pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_pc4_q, slot_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        consume;
    logic        rsp_write;
    logic [31:0] pc_plus4;

    assign consume   = slot_valid_q & ~stallF;
    // A response is only real in WAIT and only if its fetch was not killed.
    assign rsp_write = (state_q == StWait) & imem_rvalid & ~kill_q;
    assign pc_plus4  = pc_q + 32'd4;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIssue;
            kill_q        <= 1'b0;
            pc_q          <= RESET_PC;
            slot_valid_q  <= 1'b0;
            slot_instr_q  <= NOP_INSTR;
            slot_pc4_q    <= 32'd0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= NOP_INSTR;
            skid_pc4_q    <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            pc_q          <= pc_d;
            slot_valid_q  <= slot_valid_d;
            slot_instr_q  <= slot_instr_d;
            slot_pc4_q    <= slot_pc4_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc4_q    <= skid_pc4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Buffer, PC and counter next state
    always_comb begin
        slot_valid_d  = slot_valid_q;
        slot_instr_d  = slot_instr_q;
        slot_pc4_d    = slot_pc4_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc4_d    = skid_pc4_q;
        pc_d          = pc_q;
        // A slot consumed in a redirect cycle still counts.
        fetch_count_d = consume ? fetch_count_q + 32'd1 : fetch_count_q;

        if (redirect_valid) begin
            slot_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            pc_d         = redirect_pc;
        end else begin
            if (consume) begin
                if (skid_valid_q) begin
                    slot_valid_d = 1'b1;
                    slot_instr_d = skid_instr_q;
                    slot_pc4_d   = skid_pc4_q;
                    skid_valid_d = 1'b0;
                end else begin
                    slot_valid_d = 1'b0;
                end
            end
            // The skid is always empty in WAIT, so a response never collides
            // with a skid-to-slot move.
            if (rsp_write) begin
                pc_d = pc_plus4;
                if (!slot_valid_q || consume) begin
                    slot_valid_d = 1'b1;
                    slot_instr_d = imem_rdata;
                    slot_pc4_d   = pc_plus4;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_rdata;
                    skid_pc4_d   = pc_plus4;
                end
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        if (redirect_valid) begin
            kill_d = 1'b0;
            unique case (state_q)
                StIssue: begin
                    // An accepted old request is still in flight: kill it.
                    if (imem_ready) begin
                        state_d = StWait;
                        kill_d  = 1'b1;
                    end
                end
                StWait: begin
                    if (imem_rvalid) state_d = StIssue;
                    else             kill_d  = 1'b1;
                end
                default: state_d = StIssue;
            endcase
        end else begin
            unique case (state_q)
                StIssue: begin
                    if (imem_ready) state_d = StWait;
                end
                StWait: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = StIssue;
                        end else begin
                            state_d = skid_valid_d ? StBlocked : StIssue;
                        end
                    end
                end
                default: begin
                    if (!skid_valid_d) state_d = StIssue;
                end
            endcase
        end
    end

    // Outputs, all from registers
    always_comb begin
        imem_req    = (state_q == StIssue);
        imem_addr   = pc_q;
        validF      = slot_valid_q;
        instrF      = slot_valid_q ? slot_instr_q : NOP_INSTR;
        pc_plus4F   = slot_valid_q ? slot_pc4_q : 32'd0;
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: normal fetch, stall fill/drain, redirects in
// each state, reset mid-fetch with a stray response, and PC wrap.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0 = 32'h1111_0093;
    localparam logic [31:0] I1 = 32'h2222_0113;
    localparam logic [31:0] I2 = 32'h3333_0193;
    localparam logic [31:0] I3 = 32'h4444_0213;
    localparam logic [31:0] I4 = 32'h5555_0293;
    localparam logic [31:0] I5 = 32'h6666_0313;
    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus4F;
    logic [31:0] instrF;
    logic        validF;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stallF        (stallF),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .pc_plus4F     (pc_plus4F),
        .instrF        (instrF),
        .validF        (validF),
        .fetch_count   (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the full presentation interface in one call.
    task automatic chk_pres(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] p4);
        chk({tag, ".validF"}, {31'd0, validF}, {31'd0, v});
        chk({tag, ".instrF"}, instrF, ins);
        chk({tag, ".pc_plus4F"}, pc_plus4F, p4);
    endtask

    initial begin
        reset = 1'b1; stallF = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        tick(); tick();
        chk("rst.req", {31'd0, imem_req}, 32'd1);
        chk("rst.addr", imem_addr, 32'h0);
        chk_pres("rst", 1'b0, NOP, 32'h0);
        chk("rst.count", fetch_count, 32'd0);
        reset = 1'b0;

        // Normal fetch: addr 0 accepted, response next cycle.
        tick();
        chk("c1.req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = I0;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c2", 1'b1, I0, 32'd4);
        chk("c2.addr", imem_addr, 32'd4);
        chk("c2.req", {31'd0, imem_req}, 32'd1);
        chk("c2.count", fetch_count, 32'd0);
        tick();
        chk("c3.valid", {31'd0, validF}, 32'd0);
        chk("c3.count", fetch_count, 32'd1);
        imem_rvalid = 1'b1; imem_rdata = I1;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c4", 1'b1, I1, 32'd8);
        chk("c4.addr", imem_addr, 32'd8);
        tick();
        chk("c5.count", fetch_count, 32'd2);
        imem_rvalid = 1'b1; imem_rdata = I2;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c6", 1'b1, I2, 32'd12);
        chk("c6.addr", imem_addr, 32'd12);

        // Stall: I2 held in slot, fetch of 12 lands in the skid, then BLOCKED.
        stallF = 1'b1;
        tick();
        chk_pres("c7", 1'b1, I2, 32'd12);
        imem_rvalid = 1'b1; imem_rdata = I3;
        tick();
        imem_rvalid = 1'b0;
        chk("c8.req", {31'd0, imem_req}, 32'd0);
        chk_pres("c8", 1'b1, I2, 32'd12);
        tick(); tick(); tick();
        chk("c11.req", {31'd0, imem_req}, 32'd0);
        chk_pres("c11", 1'b1, I2, 32'd12);
        chk("c11.count", fetch_count, 32'd2);
        stallF = 1'b0;
        tick();
        chk_pres("c12", 1'b1, I3, 32'd16);
        chk("c12.count", fetch_count, 32'd3);
        chk("c12.req", {31'd0, imem_req}, 32'd1);
        chk("c12.addr", imem_addr, 32'd16);
        tick();
        chk("c13.valid", {31'd0, validF}, 32'd0);
        chk("c13.count", fetch_count, 32'd4);

        // Redirect while waiting for addr 16: its response must be dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("c14.req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = STALE;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c15", 1'b0, NOP, 32'd0);
        chk("c15.addr", imem_addr, 32'h100);
        chk("c15.req", {31'd0, imem_req}, 32'd1);
        tick();
        imem_rvalid = 1'b1; imem_rdata = I4;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c17", 1'b1, I4, 32'h104);
        chk("c17.addr", imem_addr, 32'h104);
        tick();
        chk("c18.count", fetch_count, 32'd5);

        // Redirect coinciding with the response for 0x104.
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        imem_rvalid = 1'b1; imem_rdata = STALE;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c19", 1'b0, NOP, 32'd0);
        chk("c19.addr", imem_addr, 32'h200);
        chk("c19.req", {31'd0, imem_req}, 32'd1);

        // Redirect in ISSUE with the request not accepted.
        imem_ready = 1'b0; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("c20.addr", imem_addr, 32'h300);
        chk("c20.req", {31'd0, imem_req}, 32'd1);
        chk("c20.valid", {31'd0, validF}, 32'd0);
        imem_ready = 1'b1;
        tick();

        // Reset mid-WAIT, then a stray response while in ISSUE.
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_ready = 1'b0;
        chk("c22.addr", imem_addr, 32'h0);
        chk("c22.count", fetch_count, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = STALE;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c23", 1'b0, NOP, 32'd0);
        chk("c23.req", {31'd0, imem_req}, 32'd1);
        chk("c23.addr", imem_addr, 32'h0);

        // Redirect to the last word: pc+4 wraps to 0.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("c24.addr", imem_addr, 32'hFFFF_FFFC);
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1; imem_rdata = I5;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c26", 1'b1, I5, 32'h0);
        chk("c26.addr", imem_addr, 32'h0);
        chk("c26.count", fetch_count, 32'd0);

        // Redirect from ISSUE with an accepted request while the slot is
        // consumed: count increments, in-flight fetch of 0 is killed.
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("c27.valid", {31'd0, validF}, 32'd0);
        chk("c27.count", fetch_count, 32'd1);
        chk("c27.req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = STALE;
        tick();
        imem_rvalid = 1'b0;
        chk_pres("c28", 1'b0, NOP, 32'd0);
        chk("c28.addr", imem_addr, 32'h40);
        chk("c28.req", {31'd0, imem_req}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register of the RV32IM 5-stage core.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request and valid-only response handshake. Allows one outstanding request.
- Buffers up to two returned instructions (output slot plus a skid entry) while decode stalls, and presents pc_plus4F/instrF/validF to IF/ID.
- Handles taken-branch/jump redirects from EX, including killing an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on instrF when validF=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- stallF  in  1  hazard unit stall; IF/ID does not capture in a cycle where stallF=1.
- redirect_valid  in  1  EX taken branch/jump, single-cycle pulse.
- redirect_pc  in  32  redirect target, word-aligned.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address (= current PC).
- imem_ready  in  1  memory accepts the request this cycle when imem_req & imem_ready.
- imem_rvalid  in  1  response valid, one-cycle pulse, at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- pc_plus4F  out  32  PC+4 of the presented instruction.
- instrF  out  32  presented instruction.
- validF  out  1  presented instruction is real (not a bubble).
- fetch_count  out  32  count of instructions consumed by IF/ID (validF & !stallF), for perf evaluation.

Behaviour:
- Reset (synchronous, overrides everything):
  - pc=RESET_PC; state=ISSUE; kill=0; slot and skid empty; fetch_count=0.
  - Outputs next cycle: imem_req=1, imem_addr=RESET_PC, validF=0, instrF=NOP_INSTR, pc_plus4F=0.
  - Reset mid-WAIT sets kill=0, so any later stray rvalid is ignored in ISSUE.
- Presentation:
  - validF=slot_valid; instrF = slot_valid ? slot_instr : NOP_INSTR; pc_plus4F = slot_valid ? slot_pc4 : 0. All driven from registers.
  - Slot is consumed on any cycle with !stallF.
  - On consume, the skid moves into the slot the next cycle if full; otherwise the slot empties.
- FSM states:
  - ISSUE: imem_req=1, imem_addr=pc. Go to WAIT on imem_ready. Enter ISSUE only when the skid is empty after the current cycle's moves.
  - WAIT: imem_req=0. On imem_rvalid:
    - If kill=1: drop the data, clear kill, go to ISSUE. PC already holds the redirect target.
    - Else: write {imem_rdata, pc+4} to the slot if the slot is empty or consumed this cycle; otherwise write it to the skid.
    - Then set pc=pc+4 and go to ISSUE if the skid is empty; otherwise go to BLOCKED.
  - BLOCKED: imem_req=0. Go to ISSUE in the cycle after the skid drains.
- Arithmetic:
  - pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC gives 0).
  - fetch_count wraps modulo 2^32.
- Redirect (priority over stallF and all normal updates):
  - Next cycle: slot and skid empty, so validF=0; pc=redirect_pc.
  - From ISSUE with imem_ready=0: stay in ISSUE, imem_addr=redirect_pc next cycle. Protocol permits address change while unaccepted.
  - From ISSUE with imem_ready=1: the accepted old request is in flight; go to WAIT with kill=1.
  - From WAIT: kill=1 unless imem_rvalid is in the same cycle, in which case drop that data, kill=0, go to ISSUE.
  - From BLOCKED: go to ISSUE.
  - A slot consumed in the redirect cycle still increments fetch_count.
- Ignore imem_rvalid outside WAIT.
- Throughput: with 1-cycle memory latency and no stalls, one instruction per 2 cycles; latency from acceptance to validF is rvalid cycle + 1.

Test Plan:
- Reset, imem_ready=1, rvalid one cycle after each acceptance, stallF=0:
  - imem_addr sequence 0,4,8.
  - instrF shows returned words with pc_plus4F 4,8,12 and validF=1.
  - fetch_count increments once per presented instruction.
- Hold stallF=1 for 6 cycles after the first instruction: slot and skid fill, imem_req=0 (BLOCKED), instrF held. On release, two instructions drain in order, then fetching resumes at pc 8.
- Redirect while in WAIT for addr 4, redirect_pc=32'h100: rvalid data for 4 is discarded, next imem_addr=0x100, next validF instruction has pc_plus4F=0x104.
- Redirect coinciding with imem_rvalid, and redirect in ISSUE with imem_ready=0:
  - No stale instruction is presented.
  - imem_addr switches to the target next cycle.
- Reset asserted mid-WAIT, then a stray rvalid: ignored. Fetch restarts at RESET_PC and fetch_count=0.
- Redirect to 32'hFFFF_FFFC: next fetch presents pc_plus4F=0 and the following imem_addr=0 (wrap).
